adc_result_framer: RTL and testbench

Downstream stage of the multislope ADC conversion controller. It accepts each 48-bit conversion result (runup count, rundown sign, runup setting, rundown count) as a single-cycle strobe and buffers it in a small FIFO, so the conversion timing never stalls. It then emits each result as a 9-byte framed packet (header, sequence, payload, checksum) over a valid/ready byte interface that feeds the UART transmitter.

---
 rtl/adc_frame_pkg.sv | 35 +++
 rtl/adc_result_framer_if.sv | 17 +
 rtl/adc_result_framer_fifo.sv | 58 +++++
 rtl/adc_result_framer.sv | 117 +++++++++++
 tb/tb_adc_result_framer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_frame_pkg.sv
// Shared definitions for the multislope ADC result path.
// Holds the framer state encodings, frame geometry and the bit layout of the
// 48-bit conversion result word, which the conversion controller also uses.
package adc_frame_pkg;

  localparam int unsigned RES_W         = 48;
  localparam int unsigned FRAME_LEN     = 9;
  localparam int unsigned PAYLOAD_BYTES = 6;

  // Result word field positions.
  localparam int unsigned RES_RUNUP_CNT_MSB   = 46;
  localparam int unsigned RES_RUNUP_CNT_LSB   = 32;
  localparam int unsigned RES_SIGN_BIT        = 31;
  localparam int unsigned RES_RUNUP_SET_MSB   = 30;
  localparam int unsigned RES_RUNUP_SET_LSB   = 16;
  localparam int unsigned RES_RUNDOWN_CNT_MSB = 15;
  localparam int unsigned RES_RUNDOWN_CNT_LSB = 0;

  // Framer states (legacy-compatible constant encoding).
  localparam int unsigned ST_W    = 3;
  localparam logic [2:0]  ST_IDLE = 3'd0;
  localparam logic [2:0]  ST_HDR  = 3'd1;
  localparam logic [2:0]  ST_SEQ  = 3'd2;
  localparam logic [2:0]  ST_PAY  = 3'd3;
  localparam logic [2:0]  ST_CSUM = 3'd4;

  // Payload byte idx of a result word; idx 0 is the most significant byte.
  function automatic logic [7:0] payload_byte(input logic [RES_W-1:0] word,
                                              input logic [2:0]       idx);
    logic [RES_W-1:0] sh;
    sh = word >> (8 * (int'(PAYLOAD_BYTES) - 1 - int'(idx)));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/adc_result_framer_if.sv
// Result-in / byte-out bus of the ADC result framer.
//   res_valid, res_data : single-cycle strobe carrying a 48-bit result
//   tx_data, tx_valid   : framed byte stream toward the UART
//   tx_ready            : UART accepts the byte on tx_valid && tx_ready
// master : the framer side; slave : the surrounding system (controller + UART).
interface adc_result_framer_if;
  logic        res_valid;
  logic [47:0] res_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (input res_valid, input res_data, input tx_ready,
                  output tx_data, output tx_valid);
  modport slave  (output res_valid, output res_data, output tx_ready,
                  input tx_data, input tx_valid);
endinterface

// File: rtl/adc_result_framer_fifo.sv
// result_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wr_data (caller never pushes when full without popping)
//   pop        : advance past rd_data (caller never pops when empty)
//   rd_data    : oldest entry, valid whenever empty is low
//   full, empty, level : occupancy status
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // NOTE: storage is deliberately left without reset; only pointers and count
  // define which entries are meaningful, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
endmodule

// File: rtl/adc_result_framer.sv
// adc_result_framer: buffers conversion results and emits each as a 9-byte
// frame: HDR, seq, 6 payload bytes (MSB first), XOR of seq and payload.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : result strobe in, valid/ready byte stream out
//   busy       : a frame is in progress
//   fifo_level : occupied result buffer entries
//   drop_cnt   : results lost to a full buffer, saturating at 255
module adc_result_framer
  import adc_frame_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  FRAME_HDR  = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  adc_result_framer_if.master           bus,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);
  logic [ST_W-1:0]  state;
  logic [2:0]       pay_idx;
  logic [7:0]       seq;
  logic [7:0]       xor_acc;
  logic [7:0]       pay_byte;
  logic [7:0]       tx_byte;
  logic [RES_W-1:0] shadow;
  logic [RES_W-1:0] fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             xfer;

  // The only pop is the IDLE->HDR step; a full buffer can still take a
  // result in that same cycle because an entry is leaving.
  assign pop  = (state == ST_IDLE) && !fifo_empty;
  assign push = bus.res_valid && (!fifo_full || pop);
  assign xfer = bus.tx_valid && bus.tx_ready;

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (bus.res_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign pay_byte = payload_byte(shadow, pay_idx);

  // Output byte is a pure function of registered state, so it holds steady
  // for as long as the UART stalls.
  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    tx_byte = 8'h00;
    case (state)
      ST_HDR:  tx_byte = FRAME_HDR;
      ST_SEQ:  tx_byte = seq;
      ST_PAY:  tx_byte = pay_byte;
      ST_CSUM: tx_byte = xor_acc;
      default: tx_byte = 8'h00;
    endcase
  end

  assign bus.tx_data  = tx_byte;
  assign bus.tx_valid = (state != ST_IDLE);
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pay_idx <= '0;
      seq     <= '0;
      xor_acc <= '0;
      shadow  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (pop) begin
          shadow  <= fifo_rd_data;
          xor_acc <= '0;
          state   <= ST_HDR;
        end
        ST_HDR: if (xfer) state <= ST_SEQ;
        ST_SEQ: if (xfer) begin
          xor_acc <= seq;
          pay_idx <= '0;
          state   <= ST_PAY;
        end
        ST_PAY: if (xfer) begin
          xor_acc <= xor_acc ^ pay_byte;
          if (pay_idx == 3'(PAYLOAD_BYTES - 1)) state <= ST_CSUM;
          else pay_idx <= pay_idx + 3'd1;
        end
        ST_CSUM: if (xfer) begin
          seq   <= seq + 8'd1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (bus.res_valid && !push && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_adc_result_framer.sv
// Self-checking bench for adc_result_framer. A queue-based frame model
// predicts the byte stream and status every cycle; directed scenarios pin
// the model with hand-computed literals.
module tb_adc_result_framer;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam logic [7:0]  FRAME_HDR  = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [7:0] drop_cnt;

  adc_result_framer_if bus ();

  adc_result_framer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FRAME_HDR  (FRAME_HDR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [47:0] m_fifo [$];
  logic [7:0]  m_cur  [$];
  logic [7:0]  m_seq  = 8'h00;
  logic [7:0]  m_drop = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete();
      m_cur.delete();
      m_seq  = 8'h00;
      m_drop = 8'h00;
    end else begin
      bit          idle;
      bit          do_pop;
      logic [47:0] w;
      logic [7:0]  b;
      logic [7:0]  cs;
      idle   = (m_cur.size() == 0);
      do_pop = idle && (m_fifo.size() > 0);
      if (!idle && bus.tx_ready) begin
        void'(m_cur.pop_front());
        if (m_cur.size() == 0) m_seq = m_seq + 8'd1;
      end
      if (do_pop) begin
        w = m_fifo.pop_front();
        m_cur.push_back(FRAME_HDR);
        m_cur.push_back(m_seq);
        cs = m_seq;
        for (int i = 0; i < 6; i++) begin
          b = w[47 - 8*i -: 8];
          m_cur.push_back(b);
          cs = cs ^ b;
        end
        m_cur.push_back(cs);
      end
      if (bus.res_valid) begin
        if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(bus.res_data);
        else if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("tx_valid", bus.tx_valid, m_cur.size() > 0);
      if (m_cur.size() > 0) check("tx_data", bus.tx_data, m_cur[0]);
      check("busy", busy, m_cur.size() > 0);
      check("fifo_level", fifo_level, m_fifo.size());
      check("drop_cnt", drop_cnt, m_drop);
    end
  end

  // Byte monitor.
  logic [7:0] mon [$];
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.tx_valid && bus.tx_ready) mon.push_back(bus.tx_data);
  end

  // tx_ready driver: 0 = level, 1 = one cycle in three, 2 = random.
  int   rdy_mode  = 0;
  logic rdy_level = 1'b0;
  int   rdy_cyc   = 0;
  always @(posedge clk) begin
    #2;
    rdy_cyc++;
    case (rdy_mode)
      1:       bus.tx_ready = (rdy_cyc % 3 == 0);
      2:       bus.tx_ready = 1'($urandom_range(0, 1));
      default: bus.tx_ready = rdy_level;
    endcase
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [47:0] rand_word();
    return {1'b0, 15'($urandom), 32'($urandom)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.res_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon.delete();
    rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [47:0] d);
    bus.res_data  = d;
    bus.res_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (!busy && fifo_level == 0 && !bus.res_valid) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  task automatic wait_not_busy(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (!busy) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  logic [7:0] exp1 [9] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03,
                           8'h04, 8'h05, 8'h06, 8'h07};
  logic [7:0] exp2 [9] = '{8'hA5, 8'h00, 8'h0A, 8'h0B, 8'h0C,
                           8'h0D, 8'h0E, 8'h0F, 8'h01};

  task automatic check_frame1(input string name);
    check({name, "_len"}, mon.size(), 9);
    for (int i = 0; i < 9 && i < mon.size(); i++) check(name, mon[i], exp1[i]);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    bus.res_valid = 1'b0;
    bus.res_data  = '0;
    bus.tx_ready  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_cnt, 8'h00);
    do_reset();

    // Single frame and latency.
    rdy_level = 1'b1;
    pulse(48'h010203040506);
    check("lat_n1_valid", bus.tx_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_n2_valid", bus.tx_valid, 1'b1);
    check("lat_n2_data", bus.tx_data, 8'hA5);
    wait_idle("single_done", 100);
    check_frame1("single_byte");

    // Backpressure: one ready cycle in three.
    do_reset();
    rdy_mode = 1;
    pulse(48'h010203040506);
    wait_idle("bp_done", 200);
    check_frame1("bp_byte");
    rdy_mode = 0;

    // Overflow: six results while stalled.
    do_reset();
    rdy_level = 1'b0;
    repeat (6) begin
      bus.res_data  = rand_word();
      bus.res_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.res_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ovf_level", fifo_level, 4);
    check("ovf_drop", drop_cnt, 8'd1);
    rdy_level = 1'b1;
    wait_idle("ovf_done", 200);
    check("ovf_len", mon.size(), 45);
    for (int f = 0; f < 5 && (9*f + 1) < mon.size(); f++)
      check("ovf_seq", mon[9*f + 1], 8'(f));

    // Simultaneous push and pop with a full buffer.
    do_reset();
    rdy_level = 1'b0;
    repeat (5) begin
      bus.res_data  = rand_word();
      bus.res_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.res_valid = 1'b0;
    @(posedge clk);
    #1;
    check("pp_full_level", fifo_level, 4);
    rdy_level = 1'b1;
    wait_not_busy("pp_reach_idle", 50);
    pulse(rand_word());
    check("pp_level", fifo_level, 4);
    check("pp_drop", drop_cnt, 8'd0);
    wait_idle("pp_done", 200);

    // Sequence wrap over 257 frames.
    do_reset();
    rdy_level = 1'b1;
    for (int i = 0; i < 257; i++) begin
      for (int t = 0; t < 50 && fifo_level >= 3; t++) begin
        @(posedge clk);
        #1;
      end
      pulse(rand_word());
    end
    wait_idle("wrap_done", 5000);
    check("wrap_len", mon.size(), 257 * 9);
    if (mon.size() == 257 * 9) begin
      logic [7:0] cs = 8'h00;
      check("wrap_last_seq", mon[256*9 + 1], 8'h00);
      check("wrap_prev_seq", mon[255*9 + 1], 8'hFF);
      for (int i = 1; i < 8; i++) cs = cs ^ mon[256*9 + i];
      check("wrap_last_csum", mon[256*9 + 8], cs);
    end

    // Drop counter saturation.
    do_reset();
    rdy_level = 1'b0;
    bus.res_valid = 1'b1;
    for (int i = 0; i < 305; i++) begin
      bus.res_data = rand_word();
      @(posedge clk);
      #1;
    end
    bus.res_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sat_drop", drop_cnt, 8'd255);
    check("sat_level", fifo_level, 4);
    rdy_level = 1'b1;
    wait_idle("sat_done", 200);

    // Mid-frame reset at payload byte 3.
    do_reset();
    rdy_level = 1'b1;
    pulse(48'h010203040506);
    for (int t = 0; t < 10 && !bus.tx_valid; t++) begin
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    check("mr_at_pay3", bus.tx_data, 8'h04);
    rst_n = 1'b0;
    #1;
    check("mr_tx_valid", bus.tx_valid, 1'b0);
    check("mr_tx_data", bus.tx_data, 8'h00);
    check("mr_busy", busy, 1'b0);
    check("mr_level", fifo_level, 0);
    check("mr_drop", drop_cnt, 8'h00);
    @(posedge clk);
    #1;
    mon.delete();
    rst_n = 1'b1;
    pulse(48'h0A0B0C0D0E0F);
    wait_idle("mr_done", 100);
    check("mr_len", mon.size(), 9);
    for (int i = 0; i < 9 && i < mon.size(); i++) check("mr_byte", mon[i], exp2[i]);

    // Randomized traffic with random backpressure.
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      bus.res_data  = rand_word();
      bus.res_valid = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      #1;
    end
    bus.res_valid = 1'b0;
    wait_idle("rand_done", 2000);
    rdy_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
